// File: rtl/tcdm_resp_bank.sv
// Single-port TCDM memory bank with a 1-cycle response path, byte enables and
// pseudo-random grant stalls from a 16-bit Galois LFSR.
module tcdm_resp_bank #(
   parameter int unsigned MEM_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter logic [7:0]  STALL_THRESH = 8'd26,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        enable_i,
   input  logic        stallable_i,
   input  logic        req_i,
   input  logic [31:0] add_i,
   input  logic        wen_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] data_i,
   output logic        gnt_o,
   output logic [31:0] r_data_o,
   output logic        r_valid_o,
   output logic        err_o,
   output logic [31:0] gnt_cnt_o,
   output logic [31:0] stall_cnt_o
);

   localparam int unsigned AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [32:0] Span = 33'(MEM_WORDS) << 2;

   logic [31:0] mem_q [MEM_WORDS];

   logic [15:0] lfsr_q, lfsr_d;
   logic        r_valid_q, r_valid_d;
   logic [31:0] r_data_q, r_data_d;
   logic        err_q, err_d;
   logic [31:0] gnt_cnt_q, gnt_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic          stall;
   logic          gnt;
   logic          stall_hit;
   logic [31:0]   offset;
   logic          in_range;
   logic [AW-1:0] idx;

   assign stall     = stallable_i & (lfsr_q[7:0] < STALL_THRESH);
   assign gnt       = req_i & enable_i & ~stall & ~clear_i;
   assign stall_hit = req_i & enable_i & stall;

   // 33-bit compare so a bank ending exactly at 2^32 never wraps into range
   assign offset   = add_i - BASE_ADDR;
   assign in_range = (add_i >= BASE_ADDR) && ({1'b0, offset} < Span);
   assign idx      = offset[AW+1:2];

   always_comb begin
      lfsr_d      = lfsr_q;
      r_valid_d   = gnt;
      r_data_d    = r_data_q;
      err_d       = err_q;
      gnt_cnt_d   = gnt_cnt_q;
      stall_cnt_d = stall_cnt_q;

      if (req_i && stallable_i) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
      if (stall_hit) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (gnt) begin
         gnt_cnt_d = gnt_cnt_q + 32'd1;
         if (!wen_i) begin
            r_data_d = 32'h0;
         end else if (in_range) begin
            r_data_d = mem_q[idx];
         end else begin
            r_data_d = 32'hDEAD_BEEF;
         end
         if (!in_range) begin
            err_d = 1'b1;
         end
      end

      // Soft clear wins over everything except memory contents and r_data
      if (clear_i) begin
         lfsr_d      = LFSR_SEED;
         r_valid_d   = 1'b0;
         err_d       = 1'b0;
         gnt_cnt_d   = 32'h0;
         stall_cnt_d = 32'h0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q      <= LFSR_SEED;
         r_valid_q   <= 1'b0;
         r_data_q    <= 32'h0;
         err_q       <= 1'b0;
         gnt_cnt_q   <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         lfsr_q      <= lfsr_d;
         r_valid_q   <= r_valid_d;
         r_data_q    <= r_data_d;
         err_q       <= err_d;
         gnt_cnt_q   <= gnt_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk_i) begin
      if (gnt && !wen_i && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[idx][8*b +: 8] <= data_i[8*b +: 8];
            end
         end
      end
   end

   assign gnt_o       = gnt;
   assign r_data_o    = r_data_q;
   assign r_valid_o   = r_valid_q;
   assign err_o       = err_q;
   assign gnt_cnt_o   = gnt_cnt_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_tcdm_resp_bank.sv
// Directed, table-driven bench for tcdm_resp_bank with hand-written sequences
// for clear, enable, random stalls and mid-transaction reset.
module tb_tcdm_resp_bank;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int unsigned MEMW = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear, enable, stallable, req, wen;
   logic [31:0] add, data;
   logic [3:0]  be;
   logic        gnt, r_valid, err;
   logic [31:0] r_data, gnt_cnt, stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tcdm_resp_bank #(
      .MEM_WORDS    (MEMW),
      .BASE_ADDR    (BASE),
      .STALL_THRESH (8'd128),
      .LFSR_SEED    (16'hACE1)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .enable_i    (enable),
      .stallable_i (stallable),
      .req_i       (req),
      .add_i       (add),
      .wen_i       (wen),
      .be_i        (be),
      .data_i      (data),
      .gnt_o       (gnt),
      .r_data_o    (r_data),
      .r_valid_o   (r_valid),
      .err_o       (err),
      .gnt_cnt_o   (gnt_cnt),
      .stall_cnt_o (stall_cnt)
   );

   typedef struct {
      logic        req;
      logic        wen;
      logic [31:0] add;
      logic [3:0]  be;
      logic [31:0] data;
      logic        exp_gnt;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d,
                               input logic g, input logic [31:0] rd, input logic e);
      vec_t v;
      v.req = r; v.wen = w; v.add = a; v.be = b; v.data = d;
      v.exp_gnt = g; v.exp_rdata = rd; v.exp_err = e;
      return v;
   endfunction

   function automatic logic [31:0] pat(input int i);
      return {16'hA5A5, 8'(i), ~8'(i)};
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; applies one request cycle and checks grant and response.
   task automatic step(input string name, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic eg,
                       input logic ev, input logic [31:0] erd, input logic ee);
      req = r; wen = w; add = a; be = b; data = d;
      #1;
      chk({name, ".gnt"}, gnt, eg);
      @(posedge clk);
      #1;
      chk({name, ".r_valid"}, r_valid, ev);
      chk({name, ".r_data"}, r_data, erd);
      chk({name, ".err"}, err, ee);
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] m_lfsr;
      logic        m_stall;
      int          n_gnt, exp_stall, granted, cyc;

      rst_n = 1'b0; clear = 1'b0; enable = 1'b1; stallable = 1'b0;
      req = 1'b0; wen = 1'b1; add = '0; be = '0; data = '0;

      vecs[0]  = mk(1, 0, BASE + 32'h08, 4'hF, 32'h1234_5678, 1, 32'h0, 0);
      vecs[1]  = mk(1, 1, BASE + 32'h08, 4'h0, 32'h0,         1, 32'h1234_5678, 0);
      vecs[2]  = mk(1, 0, BASE + 32'h0C, 4'hF, 32'hFFFF_FFFF, 1, 32'h0, 0);
      vecs[3]  = mk(1, 0, BASE + 32'h0C, 4'h1, 32'h0000_00AB, 1, 32'h0, 0);
      vecs[4]  = mk(1, 1, BASE + 32'h0C, 4'h0, 32'h0,         1, 32'hFFFF_FFAB, 0);
      vecs[5]  = mk(1, 0, BASE + 32'h0C, 4'hA, 32'h1122_3344, 1, 32'h0, 0);
      vecs[6]  = mk(1, 1, BASE + 32'h0D, 4'h0, 32'h0,         1, 32'h11FF_33AB, 0);
      vecs[7]  = mk(1, 0, BASE + 32'h0C, 4'h0, 32'h0,         1, 32'h0, 0);
      vecs[8]  = mk(1, 1, BASE + 32'h0C, 4'h0, 32'h0,         1, 32'h11FF_33AB, 0);
      vecs[9]  = mk(0, 1, BASE + 32'h08, 4'h0, 32'h0,         0, 32'h11FF_33AB, 0);
      vecs[10] = mk(1, 1, BASE + 32'h08, 4'h0, 32'h0,         1, 32'h1234_5678, 0);
      vecs[11] = mk(1, 0, BASE + 32'h3C, 4'hF, 32'hCAFE_F00D, 1, 32'h0, 0);
      vecs[12] = mk(1, 1, BASE + 32'h3F, 4'h0, 32'h0,         1, 32'hCAFE_F00D, 0);

      #12;
      chk("reset.r_valid", r_valid, 0);
      chk("reset.r_data", r_data, 32'h0);
      chk("reset.err", err, 0);
      chk("reset.gnt_cnt", gnt_cnt, 0);
      chk("reset.stall_cnt", stall_cnt, 0);
      chk("reset.gnt", gnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      n_gnt = 0;
      for (int i = 0; i < 13; i++) begin
         step($sformatf("vec%0d", i), vecs[i].req, vecs[i].wen, vecs[i].add, vecs[i].be,
              vecs[i].data, vecs[i].exp_gnt, vecs[i].exp_gnt, vecs[i].exp_rdata,
              vecs[i].exp_err);
         n_gnt += int'(vecs[i].exp_gnt);
      end
      chk("table.gnt_cnt", gnt_cnt, 32'(n_gnt));
      chk("table.stall_cnt", stall_cnt, 0);

      // Out of range: one past the end, then clear with a same-cycle request
      step("oor_read", 1, 1, BASE + 32'h40, 4'h0, 32'h0, 1, 1, 32'hDEAD_BEEF, 1);
      clear = 1'b1;
      step("clear_req", 1, 1, BASE + 32'h08, 4'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
      clear = 1'b0;
      chk("clear.gnt_cnt", gnt_cnt, 0);
      step("w_word0", 1, 0, BASE, 4'hF, 32'h0BAD_F00D, 1, 1, 32'h0, 0);
      step("oor_write", 1, 0, BASE + 32'h40, 4'hF, 32'h5555_5555, 1, 1, 32'h0, 1);
      step("r_word0", 1, 1, BASE, 4'h0, 32'h0, 1, 1, 32'h0BAD_F00D, 1);
      clear = 1'b1;
      step("clear_idle", 0, 1, BASE, 4'h0, 32'h0, 0, 0, 32'h0BAD_F00D, 0);
      clear = 1'b0;
      step("below_base", 1, 1, BASE - 32'h4, 4'h0, 32'h0, 1, 1, 32'hDEAD_BEEF, 1);

      // Enable low: no grant, no stall counting even while stalls are possible
      clear = 1'b1;
      step("clear2", 0, 1, BASE, 4'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
      clear = 1'b0;
      enable = 1'b0; stallable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step($sformatf("disabled%0d", i), 1, 1, BASE, 4'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
      end
      chk("disabled.stall_cnt", stall_cnt, 0);
      chk("disabled.gnt_cnt", gnt_cnt, 0);
      enable = 1'b1; stallable = 1'b0;

      for (int i = 0; i < int'(MEMW); i++) begin
         step($sformatf("preload%0d", i), 1, 0, BASE + 32'(4 * i), 4'hF, pat(i), 1, 1,
              32'h0, 0);
      end
      // Clear drops the same-cycle write and reloads the LFSR seed
      clear = 1'b1;
      step("clear3", 1, 0, BASE, 4'hF, 32'h0, 0, 0, 32'h0, 0);
      clear = 1'b0;
      chk("clear3.gnt_cnt", gnt_cnt, 0);

      stallable = 1'b1;
      m_lfsr = 16'hACE1;
      exp_stall = 0; granted = 0; cyc = 0;
      while (granted < 1000 && cyc < 20000) begin
         req = 1'b1; wen = 1'b1; be = 4'h0; data = '0;
         add = BASE + 32'(4 * (granted % int'(MEMW)));
         m_stall = (m_lfsr[7:0] < 8'd128);
         #1;
         chk("stall.gnt", gnt, !m_stall);
         @(posedge clk);
         #1;
         chk("stall.r_valid", r_valid, !m_stall);
         if (!m_stall) begin
            chk("stall.r_data", r_data, pat(granted % int'(MEMW)));
            granted++;
         end else begin
            exp_stall++;
         end
         m_lfsr = lfsr_step(m_lfsr);
         cyc++;
         @(negedge clk);
      end
      if (granted < 1000) begin
         chk("stall.timeout", 32'(granted), 32'd1000);
      end
      req = 1'b0;
      chk("stall.gnt_cnt", gnt_cnt, 32'd1000);
      chk("stall.stall_cnt", stall_cnt, 32'(exp_stall));
      chk("stall.nonzero", 32'(stall_cnt != 0), 32'd1);

      // Reset asserted while a read response is being presented
      stallable = 1'b0;
      req = 1'b1; wen = 1'b1; add = BASE + 32'h08;
      @(posedge clk);
      #1;
      chk("rst.pre_valid", r_valid, 1);
      req = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst.r_valid", r_valid, 0);
      chk("rst.r_data", r_data, 32'h0);
      chk("rst.gnt_cnt", gnt_cnt, 0);
      chk("rst.stall_cnt", stall_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst.post_valid", r_valid, 0);
      chk("rst.post_gnt_cnt", gnt_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
